rom_port_arbiter: RTL
=====================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single synchronous read port of the instruction ROM between two requesters:
//  IF (instruction fetch, multicycle core) and LD (loads of constants from code space).
//  Sits between the core and the ROM, which reads with one cycle of latency.
//  Arbitrates with fixed LD priority plus an IF starvation guard.
//  Read latency is pipelined at 2 cycles from grant; one grant per cycle at most.
// PARAMETERS
//  ADDR_W    17  byte-address width of the request ports
//  ROM_AW    15  ROM word-address width (ADDR_W-2)
//  DATA_W    32  ROM word width
//  MAX_WAIT  4   consecutive denied IF-request cycles before IF is forced to win
// PORTS
//  clock       in   1       single system clock, rising edge
//  resetn      in   1       asynchronous, active-low reset
//  if_req      in   1       IF read request; held with if_addr stable until if_gnt
//  if_addr     in   ADDR_W  IF byte address (bits [1:0] ignored)
//  if_gnt      out  1       IF request accepted this cycle (combinational)
//  if_rvalid   out  1       1-cycle pulse: if_rdata holds the word
//  if_rdata    out  DATA_W  IF read data; stable until the next if_rvalid
//  ld_req      in   1       LD read request; held with ld_addr stable until ld_gnt
//  ld_addr     in   ADDR_W  LD byte address
//  ld_gnt      out  1       LD request accepted this cycle (combinational)
//  ld_rvalid   out  1       1-cycle pulse: ld_rdata holds the word
//  ld_err      out  1       1-cycle pulse in place of ld_rvalid: misaligned address
//  ld_rdata    out  DATA_W  LD read data; stable until the next ld_rvalid
//  rom_en      out  1       ROM read enable (combinational, equals any grant)
//  rom_addr    out  ROM_AW  ROM word address = granted addr[ADDR_W-1:2]; 0 when idle
//  rom_data    in   DATA_W  ROM output, valid the cycle after rom_en
// BEHAVIOUR
//  Reset: all outputs are 0. Both rdata registers are 0, the wait counter is 0, and the pipe tags are empty.
//  Arbitration in cycle N:
//   - Only one of if_req or ld_req is high: that requester is granted.
//   - Both are high: LD wins unless wait_cnt==MAX_WAIT, in which case IF wins.
//  wait_cnt:
//   - Increments (saturating at MAX_WAIT) on each cycle if_req=1 && if_gnt=0.
//   - Clears on if_gnt or on if_req=0.
//  Misaligned LD (ld_addr[1:0]!=0):
//   - Granted normally, but rom_en stays 0 and no ROM access occurs.
//   - ld_err pulses at N+2, ld_rvalid stays 0, and ld_rdata is unchanged.
//   - IF addr[1:0] is ignored.
//  Pipeline: tag stage S1 (N+1) holds {owner, err}.
//   - At the end of N+1, rom_data is captured into the owner's rdata register.
//   - S2 (N+2) drives the rvalid or err pulse.
//  Back-to-back grants on consecutive cycles are legal.
//  The two ports' responses return in grant order and never merge.
//  A non-granted requester's rdata is never disturbed.
//  Reset asserted mid-operation: in-flight tags are dropped and no rvalid/err is emitted after deassertion.
//  Requests sampled in the first cycle after resetn rises are served normally.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - ROM_AW, DATA_W
//   - owner-tag encoding: OWN_NONE=2'd0, OWN_IF=2'd1, OWN_LD=2'd2.
//  One natural sub-module: rom_resp_pipe. It is the 2-stage tag/valid shift register with per-owner capture.
//  Arbiter, wait counter and grant logic stay in the top module.
// TESTING
//  1. Single IF: if_addr=0x8 -> rom_addr=2 and rom_en at N; if_rvalid at N+2 with if_rdata=ROM[2].
//  2. Single LD: ld_addr=0x14 -> ld_gnt at N; ld_rvalid at N+2 with ld_rdata=ROM[5]; if_rdata unchanged.
//  3. Both requesting continuously:
//     - LD is granted for 4 cycles, then IF on the 5th (wait_cnt=4).
//     - wait_cnt then clears and LD wins again.
//  4. Misaligned: ld_addr=0x6 -> ld_gnt=1 and rom_en=0; ld_err pulses at N+2 and ld_rvalid stays 0.
//  5. Back-to-back: IF@0x0, then LD@0x4 on the next cycle -> if_rvalid at N+2 and ld_rvalid at N+3 with ROM[0] and ROM[1] respectively.
//  6. Reset mid-flight: resetn low for 1 cycle at N+1 after a grant.
//     - No rvalid follows, and all outputs read 0.
//     - The next request completes in 2 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the ROM read-port arbiter slice.
//   ROM_AW  : ROM word-address width
//   DATA_W  : ROM word width
//   owner_e : response-pipe owner tag (which requester a ROM read belongs to)
package cpu_pkg;

    localparam int unsigned ROM_AW = 15;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2
    } owner_e;

endpackage

// File: rtl/rom_resp_pipe.sv
// Two-stage response pipe behind the shared ROM port.
// The grant cycle's tag enters S1. At the end of S1 the ROM word is captured
// into the owner's data register. S2 then drives that owner's valid/err pulse.
// Ports:
//   clock, resetn      : clock, async active-low reset (drops in-flight tags)
//   i_tag_owner        : owner of the read granted this cycle (OWN_NONE if idle)
//   i_tag_err          : granted LD read is misaligned (no ROM access made)
//   i_rom_data         : ROM output, valid in the cycle after the grant
//   o_if_rvalid/rdata  : IF response pulse and held data
//   o_ld_rvalid/err    : LD response pulse or misalignment error pulse
//   o_ld_rdata         : LD held data
module rom_resp_pipe #(
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  cpu_pkg::owner_e     i_tag_owner,
    input  logic                i_tag_err,
    input  logic [DATA_W-1:0]   i_rom_data,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_ld_rvalid,
    output logic                o_ld_err,
    output logic [DATA_W-1:0]   o_ld_rdata
);
    import cpu_pkg::*;

    owner_e              r_s1_owner;
    logic                r_s1_err;
    owner_e              r_s2_owner;
    logic                r_s2_err;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ld_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_owner <= OWN_NONE;
            r_s1_err   <= 1'b0;
            r_s2_owner <= OWN_NONE;
            r_s2_err   <= 1'b0;
            r_if_rdata <= '0;
            r_ld_rdata <= '0;
        end else begin
            r_s1_owner <= i_tag_owner;
            r_s1_err   <= i_tag_err;
            r_s2_owner <= r_s1_owner;
            r_s2_err   <= r_s1_err;
            // Only the owner's register moves; an errored LD never touched the ROM.
            if (r_s1_owner == OWN_IF)
                r_if_rdata <= i_rom_data;
            if (r_s1_owner == OWN_LD && !r_s1_err)
                r_ld_rdata <= i_rom_data;
        end
    end

    assign o_if_rvalid = (r_s2_owner == OWN_IF);
    assign o_ld_rvalid = (r_s2_owner == OWN_LD) && !r_s2_err;
    assign o_ld_err    = (r_s2_owner == OWN_LD) &&  r_s2_err;
    assign o_if_rdata  = r_if_rdata;
    assign o_ld_rdata  = r_ld_rdata;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single synchronous ROM read port between instruction fetch (IF)
// and constant loads (LD). LD has fixed priority; IF is forced through after
// MAX_WAIT consecutive denied request cycles. Responses arrive 2 cycles after grant.
// Ports:
//   clock, resetn              : clock, async active-low reset
//   if_req/if_addr/if_gnt      : IF request, byte address (bits [1:0] ignored), grant
//   if_rvalid/if_rdata         : IF response pulse and held data
//   ld_req/ld_addr/ld_gnt      : LD request, byte address, grant
//   ld_rvalid/ld_err/ld_rdata  : LD response pulse, misalignment error pulse, held data
//   rom_en/rom_addr/rom_data   : ROM read port (data valid the cycle after rom_en)
module rom_port_arbiter #(
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned ROM_AW   = cpu_pkg::ROM_AW,
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    output logic                ld_gnt,
    output logic                ld_rvalid,
    output logic                ld_err,
    output logic [DATA_W-1:0]   ld_rdata,
    output logic                rom_en,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data
);
    import cpu_pkg::*;

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               w_if_gnt;
    logic               w_ld_gnt;
    logic               w_ld_mis;
    logic               w_ld_rom;
    owner_e             w_tag_owner;
    logic               w_if_addr_unused;

    assign w_if_addr_unused = ^if_addr[1:0];

    assign w_ld_mis = (ld_addr[1:0] != 2'b00);
    assign w_if_gnt = if_req && (!ld_req || r_wait_cnt == WAIT_W'(MAX_WAIT));
    assign w_ld_gnt = ld_req && !w_if_gnt;
    // A misaligned LD is granted but never reaches the ROM.
    assign w_ld_rom = w_ld_gnt && !w_ld_mis;

    assign if_gnt = w_if_gnt;
    assign ld_gnt = w_ld_gnt;
    assign rom_en = w_if_gnt || w_ld_rom;

    always_comb begin
        rom_addr    = '0;
        w_tag_owner = OWN_NONE;
        if (w_if_gnt) begin
            rom_addr    = ROM_AW'(if_addr[ADDR_W-1:2]);
            w_tag_owner = OWN_IF;
        end else if (w_ld_gnt) begin
            w_tag_owner = OWN_LD;
            if (w_ld_rom)
                rom_addr = ROM_AW'(ld_addr[ADDR_W-1:2]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= '0;
        end else if (if_req && !w_if_gnt) begin
            if (r_wait_cnt != WAIT_W'(MAX_WAIT))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    rom_resp_pipe #(
        .DATA_W (DATA_W)
    ) u_resp_pipe (
        .clock       (clock),
        .resetn      (resetn),
        .i_tag_owner (w_tag_owner),
        .i_tag_err   (w_ld_gnt && w_ld_mis),
        .i_rom_data  (rom_data),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .o_ld_rvalid (ld_rvalid),
        .o_ld_err    (ld_err),
        .o_ld_rdata  (ld_rdata)
    );

endmodule
